// File: rtl/evacuacao_estacionamento_if.sv
// evacuacao_estacionamento_if: water-level flags, car count and ack in; gate, siren, pump and countdown out
interface evacuacao_estacionamento_if;
  logic        alerta;
  logic        emergencia;
  logic [7:0]  carros;
  logic        ack;
  logic        cancela_bloq;
  logic        sirene;
  logic        bomba;
  logic        fechado;
  logic        forcado;
  logic [15:0] tempo_restante;
  modport master (
    output alerta, emergencia, carros, ack,
    input  cancela_bloq, sirene, bomba, fechado, forcado, tempo_restante
  );
  modport slave (
    input  alerta, emergencia, carros, ack,
    output cancela_bloq, sirene, bomba, fechado, forcado, tempo_restante
  );
endinterface

// File: rtl/evacuacao_estacionamento.sv
// evacuacao_estacionamento: parking-lot evacuation countdown, siren, closing and drainage pump controller
module evacuacao_estacionamento #(
  parameter int EVAC_CYCLES  = 1000,
  parameter int BLINK_DIV    = 50,
  parameter int CLEAR_CYCLES = 200
) (
  input logic clk,
  input logic reset,
  evacuacao_estacionamento_if.slave bus
);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  typedef enum logic [1:0] {NORMAL, ALERT, PUMP, RECOVER} state_t;
  state_t r_state, w_state;
  logic [15:0] r_timer, r_dry, w_dry;
  logic [BW-1:0] r_blink;
  logic r_sir, r_forc, w_forc, r_cancela, r_bomba, r_fechado;
  logic w_flag, w_enter, w_tog, w_pump_stay;
  assign w_flag      = bus.alerta || bus.emergencia;
  assign w_enter     = (w_state == ALERT) && (r_state != ALERT);
  assign w_tog       = r_blink == BW'(BLINK_DIV - 1);
  assign w_pump_stay = (w_state == PUMP) && (r_state == PUMP);
  always_comb begin
    w_state = r_state;
    w_forc  = r_forc;
    w_dry   = w_flag ? 16'd0 : (&r_dry ? r_dry : r_dry + 16'd1);
    case (r_state)
      NORMAL: w_state = w_flag ? ALERT : NORMAL;
      ALERT: begin
        if (bus.carros == 8'd0) begin
          w_state = PUMP;
          w_forc  = 1'b0;
        end else if (r_timer == 16'd0) begin
          w_state = bus.emergencia ? PUMP : RECOVER;
          w_forc  = bus.emergencia ? 1'b1 : r_forc;
        end
      end
      PUMP: w_state = (w_dry == 16'(CLEAR_CYCLES)) ? RECOVER : PUMP;
      RECOVER: begin
        if (w_flag) w_state = ALERT;
        else if (bus.ack) begin
          w_state = NORMAL;
          w_forc  = 1'b0;
        end
      end
      default: w_state = NORMAL;
    endcase
  end
  // every output is registered from the next state so it tracks the edge that decided it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= NORMAL;
      r_timer   <= '0;
      r_blink   <= '0;
      r_dry     <= '0;
      r_sir     <= 1'b0;
      r_forc    <= 1'b0;
      r_cancela <= 1'b0;
      r_bomba   <= 1'b0;
      r_fechado <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_timer   <= w_enter ? 16'(EVAC_CYCLES - 1) :
                   ((w_state == ALERT) && (r_timer != 16'd0)) ? r_timer - 16'd1 : 16'd0;
      r_blink   <= (w_enter || (w_state != ALERT) || w_tog) ? '0 : r_blink + BW'(1);
      r_sir     <= w_enter ? 1'b1 : (w_state == ALERT) ? (r_sir ^ w_tog) : (w_state == PUMP);
      r_dry     <= w_pump_stay ? w_dry : 16'd0;
      r_forc    <= w_forc;
      r_cancela <= w_state != NORMAL;
      r_bomba   <= w_state == PUMP;
      r_fechado <= (w_state == PUMP) || (w_state == RECOVER);
    end
  end
  assign bus.cancela_bloq   = r_cancela;
  assign bus.sirene         = r_sir;
  assign bus.bomba          = r_bomba;
  assign bus.fechado        = r_fechado;
  assign bus.forcado        = r_forc;
  assign bus.tempo_restante = r_timer;
endmodule

// File: tb/tb_evacuacao_estacionamento.sv
// tb_evacuacao_estacionamento: directed scenarios for the evacuation controller with EVAC=8, BLINK=2, CLEAR=4
module tb_evacuacao_estacionamento;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vecs = 0;
  int errs = 0;
  logic [7:0] sp = 8'b0011_0011;
  evacuacao_estacionamento_if bus();
  evacuacao_estacionamento #(.EVAC_CYCLES(8), .BLINK_DIV(2), .CLEAR_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [20:0] ex(input logic c, input logic s, input logic b, input logic f,
                                     input logic fo, input logic [15:0] t);
    return {c, s, b, f, fo, t};
  endfunction
  task automatic chk(input string tag, input logic [20:0] exp);
    logic [20:0] obs;
    obs = {bus.cancela_bloq, bus.sirene, bus.bomba, bus.fechado, bus.forcado, bus.tempo_restante};
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h (cancela,sirene,bomba,fechado,forcado,tempo)", tag, obs, exp);
    end
  endtask
  initial begin
    bus.alerta = 1'b0;
    bus.emergencia = 1'b0;
    bus.carros = 8'd0;
    bus.ack = 1'b0;
    tick;
    chk("reset_held", ex(0, 0, 0, 0, 0, 16'd0));
    reset = 1'b0;
    tick;
    chk("normal_idle", ex(0, 0, 0, 0, 0, 16'd0));
    // 1: single alerta pulse, countdown to timeout, recover, ack
    bus.carros = 8'd5;
    bus.alerta = 1'b1;
    tick;
    bus.alerta = 1'b0;
    chk("s1_alert0", ex(1, 1, 0, 0, 0, 16'd7));
    for (int i = 1; i < 8; i++) begin
      tick;
      chk($sformatf("s1_alert%0d", i), ex(1, sp[i], 0, 0, 0, 16'(7 - i)));
    end
    tick;
    chk("s1_recover", ex(1, 0, 0, 1, 0, 16'd0));
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    chk("s1_normal", ex(0, 0, 0, 0, 0, 16'd0));
    // 2: lot empties during the third ALERT cycle
    bus.carros = 8'd3;
    bus.alerta = 1'b1;
    tick;
    bus.alerta = 1'b0;
    chk("s2_alert0", ex(1, 1, 0, 0, 0, 16'd7));
    tick;
    tick;
    chk("s2_alert2", ex(1, 0, 0, 0, 0, 16'd5));
    bus.carros = 8'd0;
    tick;
    chk("s2_pump", ex(1, 1, 1, 1, 0, 16'd0));
    tick;
    tick;
    tick;
    chk("s2_pump_dry3", ex(1, 1, 1, 1, 0, 16'd0));
    tick;
    chk("s2_recover", ex(1, 0, 0, 1, 0, 16'd0));
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    chk("s2_normal", ex(0, 0, 0, 0, 0, 16'd0));
    // 3: emergencia held, cars remain, forced pump after full countdown
    bus.carros = 8'd2;
    bus.emergencia = 1'b1;
    tick;
    chk("s3_alert0", ex(1, 1, 0, 0, 0, 16'd7));
    for (int i = 1; i < 8; i++) tick;
    chk("s3_alert7", ex(1, 0, 0, 0, 0, 16'd0));
    tick;
    chk("s3_pump_forced", ex(1, 1, 1, 1, 1, 16'd0));
    // 4: dry run interrupted by a one-cycle emergencia pulse
    bus.emergencia = 1'b0;
    tick;
    tick;
    tick;
    chk("s4_dry3", ex(1, 1, 1, 1, 1, 16'd0));
    bus.emergencia = 1'b1;
    tick;
    bus.emergencia = 1'b0;
    chk("s4_wet", ex(1, 1, 1, 1, 1, 16'd0));
    tick;
    tick;
    tick;
    chk("s4_dry3_again", ex(1, 1, 1, 1, 1, 16'd0));
    tick;
    chk("s4_recover", ex(1, 0, 0, 1, 1, 16'd0));
    // 5: alerta beats ack in RECOVER; ack ignored in ALERT
    bus.ack = 1'b1;
    bus.alerta = 1'b1;
    tick;
    bus.alerta = 1'b0;
    chk("s5_realert", ex(1, 1, 0, 0, 1, 16'd7));
    tick;
    bus.ack = 1'b0;
    chk("s5_ack_ignored", ex(1, 1, 0, 0, 1, 16'd6));
    // carros hits 0 in the same cycle the timer hits 0: unforced pump
    bus.emergencia = 1'b1;
    for (int i = 2; i < 8; i++) begin
      tick;
      chk($sformatf("s5_alert%0d", i), ex(1, sp[i], 0, 0, 1, 16'(7 - i)));
    end
    bus.carros = 8'd0;
    tick;
    chk("s5_pump_unforced", ex(1, 1, 1, 1, 0, 16'd0));
    // 6: asynchronous reset mid-PUMP
    #3;
    reset = 1'b1;
    #1;
    chk("s6_async_reset", ex(0, 0, 0, 0, 0, 16'd0));
    bus.emergencia = 1'b0;
    tick;
    chk("s6_reset_edge", ex(0, 0, 0, 0, 0, 16'd0));
    reset = 1'b0;
    tick;
    chk("s6_normal", ex(0, 0, 0, 0, 0, 16'd0));
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    chk("s6_ack_in_normal", ex(0, 0, 0, 0, 0, 16'd0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
